// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a synchronous FIFO into a valid/ready stream.
// Optional delivered-word counter enabled by defining FIFO_RD_STAT_EN.
module fifo_rd_stream #(
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               empty,
    input  logic [D_WIDTH-1:0] data_out,
    input  logic               pop_err_on_empty,
    output logic               pop,
    output logic               out_valid,
    output logic [D_WIDTH-1:0] out_data,
    input  logic               out_ready,
    output logic               err,
    output logic [15:0]        out_cnt
);

    logic [1:0]         occ;
    logic [1:0]         occ_nx;
    logic               pop_q;
    logic [1:0]         rd_ptr;
    logic [1:0]         wr_ptr;
    logic [2:0]         fill;
    logic               deq;
    logic [D_WIDTH-1:0] mem [3];

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Words already buffered plus the one in flight from the FIFO.
    always_comb begin
        fill = {1'b0, occ} + {2'b00, pop_q};
    end

    // Pop only when a free slot is guaranteed for the returning word.
    always_comb begin
        pop = rst_n & en & ~empty & (fill < 3'd3);
    end

    // Stream side is presented straight from the head register.
    always_comb begin
        out_valid = (occ != 2'd0);
        deq       = out_valid & out_ready;
        out_data  = mem[0];
        unique case (rd_ptr)
            2'd1:    out_data = mem[1];
            2'd2:    out_data = mem[2];
            default: out_data = mem[0];
        endcase
    end

    // Occupancy follows enqueue (in-flight word lands) and dequeue.
    always_comb begin
        occ_nx = occ;
        unique case ({pop_q, deq})
            2'b10:   occ_nx = occ + 2'd1;
            2'b01:   occ_nx = occ - 2'd1;
            default: occ_nx = occ;
        endcase
    end

    // Control state: occupancy, in-flight flag and ring pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ    <= 2'd0;
            pop_q  <= 1'b0;
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
        end else begin
            occ   <= occ_nx;
            pop_q <= pop;
            if (pop_q) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (deq) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // Capture the FIFO read data one cycle after each pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                mem[i] <= '0;
            end
        end else if (pop_q) begin
            mem[wr_ptr] <= data_out;
        end
    end

    // Sticky flag for any pop the FIFO reports as illegal.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (pop_err_on_empty) begin
            err <= 1'b1;
        end
    end

`ifdef FIFO_RD_STAT_EN
    logic [15:0] cnt_q;

    // Count delivered words, wrapping naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 16'h0000;
        end else if (deq) begin
            cnt_q <= cnt_q + 16'h0001;
        end
    end

    assign out_cnt = cnt_q;
`else
    assign out_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: FIFO model, scoreboard and directed tests
// for fifo_rd_stream.
module tb_fifo_rd_stream;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       empty;
    logic       empty_q;
    logic       force_ne;
    logic [7:0] data_out;
    logic       pop_err_on_empty;
    logic       pop;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       err;
    logic [15:0] out_cnt;

    logic [7:0] fq [$];
    logic [7:0] ld_q [$];
    logic [7:0] exp_q [$];
    int         pop_cnt;
    int         exp_cnt;
    int         n_cmp;
    int         n_err;
    logic       prev_stall;
    logic [7:0] prev_data;
    int         base;

    assign empty = empty_q & ~force_ne;

    fifo_rd_stream #(.D_WIDTH(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .en               (en),
        .empty            (empty),
        .data_out         (data_out),
        .pop_err_on_empty (pop_err_on_empty),
        .pop              (pop),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_ready        (out_ready),
        .err              (err),
        .out_cnt          (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // FIFO model with one-cycle registered read latency.
    initial begin
        empty_q  = 1'b1;
        data_out = 8'h00;
        pop_cnt  = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                fq.delete();
                ld_q.delete();
                data_out <= 8'h00;
                empty_q  <= 1'b1;
            end else begin
                if (pop && fq.size() != 0) begin
                    data_out <= fq.pop_front();
                    pop_cnt++;
                end
                while (ld_q.size() != 0) begin
                    fq.push_back(ld_q.pop_front());
                end
                empty_q <= (fq.size() == 0);
            end
        end
    end

    // Monitor: checks delivered words and the hold rule.
    initial begin
        exp_cnt    = 0;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                exp_q.delete();
                exp_cnt    = 0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_data", 32'(out_data), 32'(prev_data));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL extra_word: got %0h expected none",
                                 out_data);
                    end else begin
                        chk("stream_data", 32'(out_data),
                            32'(exp_q.pop_front()));
                        exp_cnt++;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    task automatic load(input logic [7:0] w, input bit expect_it);
        ld_q.push_back(w);
        if (expect_it) begin
            exp_q.push_back(w);
        end
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [31:0] want_cnt();
`ifdef FIFO_RD_STAT_EN
        return 32'(exp_cnt & 32'hFFFF);
`else
        return 32'd0;
`endif
    endfunction

    initial begin
        n_cmp            = 0;
        n_err            = 0;
        rst_n            = 1'b0;
        en               = 1'b0;
        out_ready        = 1'b0;
        pop_err_on_empty = 1'b0;
        force_ne         = 1'b0;

        // Reset state, and no pop while in reset.
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cnt", 32'(out_cnt), 32'd0);
        force_ne = 1'b1;
        en       = 1'b1;
        #1;
        chk("rst_pop", 32'(pop), 32'd0);
        force_ne = 1'b0;
        en       = 1'b0;

        // Three words, ready high: latency and back-to-back output.
        @(negedge clk);
        rst_n     = 1'b1;
        en        = 1'b1;
        out_ready = 1'b1;
        base      = pop_cnt;
        load(8'h11, 1);
        load(8'h22, 1);
        load(8'h33, 1);
        @(negedge clk);
        chk("t1_pop0", 32'(pop), 32'd1);
        chk("t1_valid0", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("t1_pop1", 32'(pop), 32'd1);
        chk("t1_valid1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("t1_pop2", 32'(pop), 32'd1);
        chk("t1_valid2", 32'(out_valid), 32'd1);
        chk("t1_first", 32'(out_data), 32'h11);
        @(negedge clk);
        chk("t1_pop3", 32'(pop), 32'd0);
        chk("t1_valid3", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("t1_valid4", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("t1_valid5", 32'(out_valid), 32'd0);
        drain("t1");
        chk("t1_pops", 32'(pop_cnt - base), 32'd3);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_cnt", 32'(out_cnt), want_cnt());

        // Five words under backpressure: only three fetched.
        out_ready = 1'b0;
        base      = pop_cnt;
        for (int i = 1; i <= 5; i++) begin
            load(8'hA0 + 8'(i), 1);
        end
        repeat (7) @(negedge clk);
        chk("t2_pops", 32'(pop_cnt - base), 32'd3);
        chk("t2_pop_off", 32'(pop), 32'd0);
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_head", 32'(out_data), 32'hA1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("t2_nobubble", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        chk("t2_done", 32'(out_valid), 32'd0);
        drain("t2");
        chk("t2_pops_all", 32'(pop_cnt - base), 32'd5);
        chk("t2_err", 32'(err), 32'd0);

        // Empty FIFO: no pops; error pulse sets sticky err.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_pop", 32'(pop), 32'd0);
            chk("t3_valid", 32'(out_valid), 32'd0);
        end
        pop_err_on_empty = 1'b1;
        @(negedge clk);
        pop_err_on_empty = 1'b0;
        chk("t3_err_set", 32'(err), 32'd1);
        repeat (3) @(negedge clk);
        chk("t3_err_hold", 32'(err), 32'd1);

        // Ten words with ready toggling: order, hold, wrap.
        for (int i = 0; i < 10; i++) begin
            load(8'h40 + 8'(i), 1);
        end
        for (int k = 0; k < 80 && exp_q.size() != 0; k++) begin
            @(negedge clk);
            out_ready = ~out_ready;
        end
        chk("t4_drained", 32'(exp_q.size()), 32'd0);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset with two buffered words and one in flight.
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            load(8'hB0 + 8'(i), 1);
        end
        repeat (4) @(negedge clk);
        chk("t5_full_pop", 32'(pop), 32'd0);
        chk("t5_full_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_pop", 32'(pop), 32'd0);
        chk("t5_rst_cnt", 32'(out_cnt), 32'd0);
        chk("t5_rst_err", 32'(err), 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t5_post_valid", 32'(out_valid), 32'd0);
        chk("t5_post_pop", 32'(pop), 32'd0);
        repeat (2) @(negedge clk);

        // Drop en right after one pop: only that word arrives.
        base = pop_cnt;
        load(8'hC1, 1);
        load(8'hC2, 0);
        load(8'hC3, 0);
        @(negedge clk);
        chk("t6_pop", 32'(pop), 32'd1);
        @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_one_pop", 32'(pop_cnt - base), 32'd1);
        chk("t6_delivered", 32'(exp_q.size()), 32'd0);
        chk("t6_idle", 32'(out_valid), 32'd0);
        chk("t6_no_pop", 32'(pop), 32'd0);
        exp_q.push_back(8'hC2);
        exp_q.push_back(8'hC3);
        en = 1'b1;
        drain("t6");
        chk("t6_pops_all", 32'(pop_cnt - base), 32'd3);
        chk("t6_cnt", 32'(out_cnt), want_cnt());
        chk("t6_err", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain stage placed directly downstream of the synchronous FIFO. It issues `pop` to the FIFO and absorbs the FIFO's one-cycle registered read latency in a 3-entry skid buffer. It presents words on a valid/ready stream to the consumer at up to one word per clock, never pops an empty FIFO, and flags any FIFO pop error it observes.

## Interface
- `D_WIDTH`, default 8: FIFO read data width and stream data width.
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `en`  in  1: drain enable; when 0, no new pops are issued, but in-flight and buffered words still drain.
- `empty`  in  1: FIFO empty flag.
- `data_out`  in  D_WIDTH: FIFO read data, valid the cycle after a pop.
- `pop_err_on_empty`  in  1: FIFO pop-on-empty error pulse.
- `pop`  out  1: FIFO pop request, combinational from registered state, `empty` and `en`.
- `out_valid`  out  1: stream word available.
- `out_data`  out  D_WIDTH: stream word, buffer head.
- `out_ready`  in  1: consumer accepts the word when `out_valid & out_ready`.
- `err`  out  1: sticky; set when `pop_err_on_empty` is seen.
- `out_cnt`  out  16: count of delivered words; see Configuration.

## Operation
- State:
  - `occ[1:0]`: buffer occupancy, 0..3.
  - `pop_q`: registered `pop`, meaning one word is in flight.
  - 3-entry circular buffer with `rd_ptr`/`wr_ptr`, each mod 3.
  - `err`.
  - `out_cnt` (optional).
- Pop rule: `pop = rst_n & en & !empty & (occ + pop_q < 3)`.
  - Uses only registered state, so there is no combinational path from `out_ready` to `pop`.
- Capture: when `pop_q` = 1, write `data_out` at `wr_ptr`, then advance `wr_ptr`.
- Dequeue: on `out_valid & out_ready`, advance `rd_ptr`.
- Occupancy: `occ_next = occ + pop_q - (out_valid & out_ready)`.
  - Simultaneous enqueue and dequeue leave `occ` unchanged.
  - Never exceeds 3, guaranteed by the pop rule.
- Output: `out_valid = (occ != 0)`; `out_data = buf[rd_ptr]`, the head register, not bypassed from `data_out`.
- `err` is set on any cycle where `pop_err_on_empty` = 1 and holds until reset.
  - Correct operation never sets it; it exists as a bench and integration check.
- `en` falling while a pop is in flight: the in-flight word is still captured. No word is lost or duplicated.

## Timing
- Reset (rst_n = 0 at a rising edge) sets:
  - `occ` = 0, `pop_q` = 0, both pointers = 0.
  - `err` = 0, `out_cnt` = 0.
  - `out_valid` = 0. `out_data` is don't-care, but buffer registers are reset to 0.
- During reset, `pop` = 0 combinationally.
- Reset mid-transfer discards buffered and in-flight words.
  - The FIFO, on the same reset, is also cleared.
- Latency: pop in cycle N → word captured at the edge ending N+1 → `out_valid` = 1 in cycle N+2.
  - First word from an idle, non-empty FIFO appears 2 cycles after `empty` falls.
- Throughput: 1 word/clk sustained when `out_ready` = 1 (steady state `occ` = 1, `pop_q` = 1).
- Backpressure: with `out_ready` = 0, at most 3 words are buffered.
  - `pop` deasserts when `occ + pop_q` = 3.
- Stream rule: while `out_valid` = 1 and `out_ready` = 0, `out_data` and `out_valid` are held stable.
- Wrap-around: pointers wrap 2 → 0.
- `empty` = 1 in cycle N: no pop in N, regardless of occupancy.

## Configuration
- `FIFO_RD_STAT_EN` defined:
  - `out_cnt` is a 16-bit counter incremented on each `out_valid & out_ready`.
  - Wraps 0xFFFF → 0x0000; reset to 0.
- Not defined: `out_cnt` is tied to 16'h0000 and no counter logic is built.

## Test plan
- Reset, then preload FIFO with 0x11, 0x22, 0x33, `out_ready` = 1, `en` = 1:
  - `pop` high for 3 consecutive cycles.
  - `out_data` = 0x11/0x22/0x33 on consecutive cycles, first one 2 cycles after the first pop.
  - `err` = 0; `out_cnt` = 3 (stat build).
- Preload 5 words, hold `out_ready` = 0:
  - exactly 3 pops, `occ` = 3, `pop` = 0 thereafter.
  - Then `out_ready` = 1: all 5 words come out in order, with no bubble after the first.
- FIFO empty throughout: `pop` never asserts, `out_valid` = 0.
  - Force `pop_err_on_empty` = 1 for one cycle: `err` = 1 and stays 1 until `rst_n` = 0.
- Stream 10 words with `out_ready` toggling 1,0,1,0…: order is preserved and `out_data` is stable while stalled.
  - Pointers wrap at least 3 times.
- Assert `rst_n` = 0 for 1 cycle with `occ` = 2 and `pop_q` = 1:
  - next cycle `out_valid` = 0, `pop` = 0 during reset, and `out_cnt` = 0.
- Drop `en` the cycle after a pop: the in-flight word is still delivered and no further pops occur.
